// File: rtl/i2c_reg_slave.sv
// I2C register target: {addr+R/W, sub-address, data...} burst writes and auto-incrementing
// reads against a host-side byte register port. SCL/SDA are oversampled and filtered on iCLK.
`timescale 1ns/1ps
module i2c_reg_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h39,
    parameter int         FILT_LEN   = 3
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic       oWR,
    output logic [7:0] oADDR,
    output logic [7:0] oWDATA,
    input  logic [7:0] iRDATA,
    output logic       oBUSY,
    output logic       oNACKED
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ACK_ADDR, S_SUB, S_ACK_SUB, S_WR, S_ACK_WR,
        S_RD, S_RD_ACK, S_RD_NEXT, S_IGNORE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
    logic [FILT_LEN-1:0] r_scl_hist, r_sda_hist;
    logic                r_scl_f, r_sda_f, r_scl_q, r_sda_q;
    logic                r_sda_oe, r_wr, r_busy, r_nacked, r_rw;
    logic                r_rd_loaded, r_rd_wait;
    logic [7:0]          r_addr, r_wdata, r_shift, r_tx;
    logic [3:0]          r_bitcnt;
    logic                w_sda_in, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic                w_addr_match, w_byte_end;

    // Open-drain: only ever pull low or release.
    assign I2C_SDAT = r_sda_oe ? 1'b0 : 1'bz;
    assign w_sda_in = I2C_SDAT;

    assign oWR     = r_wr;
    assign oADDR   = r_addr;
    assign oWDATA  = r_wdata;
    assign oBUSY   = r_busy;
    assign oNACKED = r_nacked;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_scl_s1   <= 1'b1;
            r_scl_s2   <= 1'b1;
            r_sda_s1   <= 1'b1;
            r_sda_s2   <= 1'b1;
            r_scl_hist <= '1;
            r_sda_hist <= '1;
            r_scl_f    <= 1'b1;
            r_sda_f    <= 1'b1;
            r_scl_q    <= 1'b1;
            r_sda_q    <= 1'b1;
        end else begin
            r_scl_s1   <= I2C_SCLK;
            r_scl_s2   <= r_scl_s1;
            r_sda_s1   <= w_sda_in;
            r_sda_s2   <= r_sda_s1;
            r_scl_hist <= {r_scl_hist[FILT_LEN-2:0], r_scl_s2};
            r_sda_hist <= {r_sda_hist[FILT_LEN-2:0], r_sda_s2};
            // A new level is accepted only after FILT_LEN identical samples.
            if (&r_scl_hist)
                r_scl_f <= 1'b1;
            else if (~|r_scl_hist)
                r_scl_f <= 1'b0;
            if (&r_sda_hist)
                r_sda_f <= 1'b1;
            else if (~|r_sda_hist)
                r_sda_f <= 1'b0;
            r_scl_q <= r_scl_f;
            r_sda_q <= r_sda_f;
        end
    end

    assign w_scl_rise   = r_scl_f & ~r_scl_q;
    assign w_scl_fall   = ~r_scl_f & r_scl_q;
    assign w_start      = r_scl_f & r_scl_q & r_sda_q & ~r_sda_f;
    assign w_stop       = r_scl_f & r_scl_q & ~r_sda_q & r_sda_f;
    assign w_addr_match = (r_shift[7:1] == SLAVE_ADDR);
    assign w_byte_end   = w_scl_fall && (r_bitcnt == 4'd8);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else if (w_start) begin
            w_state_nxt = S_ADDR;
        end else begin
            case (r_state)
                S_ADDR:
                    if (w_byte_end)
                        w_state_nxt = w_addr_match ? S_ACK_ADDR : S_IGNORE;
                S_ACK_ADDR:
                    if (w_scl_fall)
                        w_state_nxt = r_rw ? S_RD : S_SUB;
                S_SUB:
                    if (w_byte_end)
                        w_state_nxt = S_ACK_SUB;
                S_ACK_SUB:
                    if (w_scl_fall)
                        w_state_nxt = S_WR;
                S_WR:
                    if (w_byte_end)
                        w_state_nxt = S_ACK_WR;
                S_ACK_WR:
                    if (w_scl_fall)
                        w_state_nxt = S_WR;
                S_RD:
                    if (w_byte_end)
                        w_state_nxt = S_RD_ACK;
                S_RD_ACK:
                    if (w_scl_rise)
                        w_state_nxt = r_sda_f ? S_IGNORE : S_RD_NEXT;
                S_RD_NEXT:
                    if (w_scl_fall)
                        w_state_nxt = S_RD;
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_sda_oe    <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= 8'h00;
            r_wdata     <= 8'h00;
            r_busy      <= 1'b0;
            r_nacked    <= 1'b0;
            r_rw        <= 1'b0;
            r_bitcnt    <= 4'd0;
            r_shift     <= 8'h00;
            r_tx        <= 8'h00;
            r_rd_loaded <= 1'b0;
            r_rd_wait   <= 1'b0;
        end else begin
            r_wr <= 1'b0;
            // Post-write auto-increment lands the cycle after the strobe.
            if (r_wr)
                r_addr <= r_addr + 8'd1;
            if (w_stop) begin
                r_busy   <= 1'b0;
                r_sda_oe <= 1'b0;
            end else if (w_start) begin
                r_busy   <= 1'b1;
                r_nacked <= 1'b0;
                r_sda_oe <= 1'b0;
                r_bitcnt <= 4'd0;
            end else begin
                case (r_state)
                    S_ADDR, S_SUB, S_WR: begin
                        if (w_scl_rise && r_bitcnt != 4'd8) begin
                            r_shift  <= {r_shift[6:0], r_sda_f};
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                        if (w_byte_end) begin
                            r_bitcnt <= 4'd0;
                            r_sda_oe <= (r_state != S_ADDR) || w_addr_match;
                            if (r_state == S_ADDR)
                                r_rw <= r_shift[0];
                            if (r_state == S_SUB)
                                r_addr <= r_shift;
                            if (r_state == S_WR) begin
                                r_wdata <= r_shift;
                                r_wr    <= 1'b1;
                            end
                        end
                    end
                    S_ACK_ADDR, S_ACK_SUB, S_ACK_WR, S_RD_NEXT: begin
                        if (w_scl_fall) begin
                            r_sda_oe    <= 1'b0;
                            r_bitcnt    <= 4'd0;
                            r_rd_loaded <= 1'b0;
                            r_rd_wait   <= 1'b0;
                        end
                    end
                    S_RD: begin
                        // Give the register file two cycles to present iRDATA for oADDR.
                        if (!r_rd_loaded) begin
                            r_rd_wait <= 1'b1;
                            if (r_rd_wait) begin
                                r_tx        <= iRDATA;
                                r_sda_oe    <= ~iRDATA[7];
                                r_rd_loaded <= 1'b1;
                            end
                        end else if (w_scl_rise && r_bitcnt != 4'd8) begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bitcnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                            end else begin
                                r_tx     <= {r_tx[6:0], 1'b1};
                                r_sda_oe <= ~r_tx[6];
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (w_scl_rise) begin
                            if (r_sda_f)
                                r_nacked <= 1'b1;
                            else
                                r_addr <= r_addr + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: bit-level I2C initiator plus a write-strobe scoreboard.
`timescale 1ns/1ps
module tb_i2c_reg_slave;

    localparam int Q = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        tb_sda_low = 1'b0;
    logic        glitch = 1'b0;
    wire         sda;
    logic        wr, busy, nacked;
    logic [7:0]  addr, wdata, rdata;
    logic [7:0]  mem [0:255];
    logic [15:0] exp_q [$];
    logic [15:0] e;
    logic [7:0]  d;
    int          errors = 0;
    int          checks = 0;

    always #10 clk = ~clk;

    assign sda = tb_sda_low ? 1'b0 : 1'bz;
    pullup pu (sda);
    assign rdata = mem[addr];

    i2c_reg_slave #(.SLAVE_ADDR(7'h39), .FILT_LEN(3)) dut (
        .iCLK    (clk),
        .iRST    (rst),
        .I2C_SCLK(scl),
        .I2C_SDAT(sda),
        .oWR     (wr),
        .oADDR   (addr),
        .oWDATA  (wdata),
        .iRDATA  (rdata),
        .oBUSY   (busy),
        .oNACKED (nacked)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (wr) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr: got addr=%02h data=%02h, required no write", addr, wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {24'h0, addr}, {24'h0, e[15:8]});
                chk("wr_data", {24'h0, wdata}, {24'h0, e[7:0]});
            end
        end
    end

    task automatic q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        tb_sda_low = 1'b0; q();
        scl = 1'b1; q();
        tb_sda_low = 1'b1; q();
        scl = 1'b0; q();
    endtask

    task automatic i2c_stop();
        tb_sda_low = 1'b1; q();
        scl = 1'b1; q();
        tb_sda_low = 1'b0; q();
    endtask

    task automatic wbit(input logic b);
        tb_sda_low = ~b; q();
        if (glitch) begin
            scl = 1'b1; @(negedge clk);
            scl = 1'b0; @(negedge clk);
        end
        scl = 1'b1; q();
        if (glitch) begin
            tb_sda_low = b; @(negedge clk);
            tb_sda_low = ~b;
        end
        q();
        scl = 1'b0; q();
    endtask

    task automatic rbit(output logic b);
        tb_sda_low = 1'b0; q();
        scl = 1'b1; q();
        b = sda; q();
        scl = 1'b0; q();
    endtask

    task automatic wbyte(input logic [7:0] dat, input logic exp_ack, input string nm);
        logic a;
        logic ack;
        for (int i = 7; i >= 0; i--) wbit(dat[i]);
        rbit(a);
        ack = ~a;
        chk(nm, {31'h0, ack}, {31'h0, exp_ack});
    endtask

    task automatic rbyte(output logic [7:0] dat, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            dat[i] = b;
        end
        wbit(~ack);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: time limit reached, required $finish before it");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h41] = 8'h10;
        mem[8'h42] = 8'hA8;

        repeat (5) @(negedge clk);
        chk("rst_wr", {31'h0, wr}, 0);
        chk("rst_addr", {24'h0, addr}, 0);
        chk("rst_wdata", {24'h0, wdata}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_nacked", {31'h0, nacked}, 0);
        chk("rst_sda", {31'h0, sda}, 1);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // single write
        i2c_start();
        wbyte(8'h72, 1'b1, "t1_ack_dev");
        wbyte(8'h98, 1'b1, "t1_ack_sub");
        exp_q.push_back(16'h9803);
        wbyte(8'h03, 1'b1, "t1_ack_data");
        chk("t1_busy_in", {31'h0, busy}, 1);
        i2c_stop();
        repeat (20) @(negedge clk);
        chk("t1_busy_after", {31'h0, busy}, 0);
        chk("t1_pending", exp_q.size(), 0);
        chk("t1_addr_inc", {24'h0, addr}, 32'h99);

        // burst with address wrap
        exp_q.push_back(16'hFE11);
        exp_q.push_back(16'hFF22);
        exp_q.push_back(16'h0033);
        i2c_start();
        wbyte(8'h72, 1'b1, "t2_ack_dev");
        wbyte(8'hFE, 1'b1, "t2_ack_sub");
        wbyte(8'h11, 1'b1, "t2_ack_d0");
        wbyte(8'h22, 1'b1, "t2_ack_d1");
        wbyte(8'h33, 1'b1, "t2_ack_d2");
        i2c_stop();
        repeat (20) @(negedge clk);
        chk("t2_pending", exp_q.size(), 0);
        chk("t2_addr_wrap", {24'h0, addr}, 32'h01);

        // wrong device address
        i2c_start();
        wbyte(8'h70, 1'b0, "t3_noack_dev");
        wbyte(8'h98, 1'b0, "t3_noack_sub");
        wbyte(8'h03, 1'b0, "t3_noack_data");
        i2c_stop();
        repeat (20) @(negedge clk);
        chk("t3_busy_after", {31'h0, busy}, 0);
        chk("t3_wdata_kept", {24'h0, wdata}, 32'h33);

        // set address then repeated-start read
        i2c_start();
        wbyte(8'h72, 1'b1, "t4_ack_dev");
        wbyte(8'h41, 1'b1, "t4_ack_sub");
        i2c_start();
        wbyte(8'h73, 1'b1, "t4_ack_rd");
        rbyte(d, 1'b1);
        chk("t4_rd0", {24'h0, d}, 32'h10);
        rbyte(d, 1'b0);
        chk("t4_rd1", {24'h0, d}, 32'hA8);
        chk("t4_nacked", {31'h0, nacked}, 1);
        i2c_stop();
        repeat (20) @(negedge clk);
        chk("t4_nacked_sticky", {31'h0, nacked}, 1);
        chk("t4_addr", {24'h0, addr}, 32'h42);
        chk("t4_busy_after", {31'h0, busy}, 0);

        // reset during data ACK, then a clean write
        i2c_start();
        wbyte(8'h72, 1'b1, "t5_ack_dev");
        wbyte(8'h10, 1'b1, "t5_ack_sub");
        exp_q.push_back(16'h1077);
        for (int i = 7; i >= 0; i--) wbit(((8'h77 >> i) & 8'h01) != 8'h00);
        tb_sda_low = 1'b0; q();
        chk("t5_ack_driven", {31'h0, sda}, 0);
        rst = 1'b1;
        #1;
        chk("t5_sda_released", {31'h0, sda}, 1);
        chk("t5_rst_wr", {31'h0, wr}, 0);
        chk("t5_rst_addr", {24'h0, addr}, 0);
        chk("t5_rst_wdata", {24'h0, wdata}, 0);
        chk("t5_rst_busy", {31'h0, busy}, 0);
        chk("t5_rst_nacked", {31'h0, nacked}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        scl = 1'b1; q();
        i2c_start();
        wbyte(8'h72, 1'b1, "t5_ack_dev2");
        wbyte(8'h20, 1'b1, "t5_ack_sub2");
        exp_q.push_back(16'h205A);
        wbyte(8'h5A, 1'b1, "t5_ack_data2");
        i2c_stop();
        repeat (20) @(negedge clk);
        chk("t5_pending", exp_q.size(), 0);

        // partial byte aborted by repeated START, with short glitches on both lines
        glitch = 1'b1;
        i2c_start();
        wbyte(8'h72, 1'b1, "t6_ack_dev");
        wbyte(8'h10, 1'b1, "t6_ack_sub");
        wbit(1'b1);
        wbit(1'b0);
        wbit(1'b1);
        wbit(1'b1);
        i2c_start();
        wbyte(8'h72, 1'b1, "t6_ack_dev2");
        wbyte(8'h10, 1'b1, "t6_ack_sub2");
        exp_q.push_back(16'h1055);
        wbyte(8'h55, 1'b1, "t6_ack_data2");
        i2c_stop();
        glitch = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_pending", exp_q.size(), 0);
        chk("t6_addr_inc", {24'h0, addr}, 32'h11);
        chk("t6_busy_after", {31'h0, busy}, 0);

        repeat (50) @(negedge clk);
        chk("final_pending", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
